// File: rtl/plru_array.sv
// plru_array: per-set tree pseudo-LRU state with registered lookup and pipelined touch
module plru_array #(
    parameter int S_INDEX = 4,
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS),
    localparam int NUM_SETS = 2**S_INDEX
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               clr,
    input  logic               csb0,
    input  logic [S_INDEX-1:0] addr0,
    input  logic [WAYS-1:0]    valid0,
    output logic [WAY_W-1:0]   victim0,
    output logic [WAYS-2:0]    state0,
    input  logic               csb1,
    input  logic [S_INDEX-1:0] addr1,
    input  logic [WAY_W-1:0]   way1
);
    logic [WAYS-2:0]    tree [NUM_SETS];
    logic [S_INDEX-1:0] la, pa;
    logic [WAYS-1:0]    lv;
    logic               pv;
    logic [WAY_W-1:0]   pw, tv;
    logic [WAYS-2:0]    upd, cur;

    function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] s, input logic [WAY_W-1:0] w);
        int n;
        n = 0;
        touch = s;
        for (int l = 0; l < WAY_W; l++) begin
            touch[n] = !w[WAY_W-1-l];
            n = 2*n + 1 + int'(w[WAY_W-1-l]);
        end
    endfunction

    function automatic logic [WAY_W-1:0] walk(input logic [WAYS-2:0] s);
        int n;
        n = 0;
        walk = '0;
        for (int l = 0; l < WAY_W; l++) begin
            walk[WAY_W-1-l] = s[n];
            n = 2*n + 1 + int'(s[n]);
        end
    endfunction

    // A pending touch to the looked-up set is forwarded ahead of its array write
    always_comb begin
        upd = touch(tree[pa], pw);
        cur = (pv && pa == la) ? upd : tree[la];
        tv = walk(cur);
        victim0 = tv;
        for (int i = WAYS-1; i >= 0; i--)
            if (!lv[i]) victim0 = WAY_W'(i);
        state0 = cur;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            for (int i = 0; i < NUM_SETS; i++) tree[i] <= '0;
            pv <= 1'b0;
            la <= '0;
            lv <= '1;
        end else begin
            if (clr) begin
                for (int i = 0; i < NUM_SETS; i++) tree[i] <= '0;
            end else if (pv) begin
                tree[pa] <= upd;
            end
            if (!csb0) begin
                la <= addr0;
                lv <= valid0;
            end
            pv <= !csb1 && !clr;
            if (!csb1) begin
                pa <= addr1;
                pw <= way1;
            end
        end
    end
endmodule
